// File: rtl/chimera_cluster_pmu_apb.sv
// APB-controlled power sequencer for the Chimera clusters: one FSM per cluster
// steps power, clock, reset and isolation in order and flags completion by interrupt.
module chimera_cluster_pmu_apb #(
    parameter int NumClusters = 5,
    parameter int AddrWidth   = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic                   pwrite_i,
    input  logic [AddrWidth-1:0]   paddr_i,
    input  logic [31:0]            pwdata_i,
    input  logic [3:0]             pstrb_i,
    output logic                   pready_o,
    output logic [31:0]            prdata_o,
    output logic                   pslverr_o,
    output logic [NumClusters-1:0] pwr_req_o,
    input  logic [NumClusters-1:0] pwr_ack_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_o,
    output logic [NumClusters-1:0] iso_o,
    output logic                   irq_o
);
    localparam int N = NumClusters;

    typedef enum logic [2:0] {
        S_OFF, S_PWR_UP, S_CLK_UP, S_RST_UP, S_ON, S_ISO_DN, S_RST_DN, S_PWR_DN
    } state_t;

    // {pwr, clk_en, rst, iso} for each state
    function automatic logic [3:0] moore(input state_t s);
        case (s)
            S_PWR_UP: moore = 4'b1011;
            S_CLK_UP: moore = 4'b1111;
            S_RST_UP: moore = 4'b1101;
            S_ON:     moore = 4'b1100;
            S_ISO_DN: moore = 4'b1101;
            S_RST_DN: moore = 4'b1111;
            default:  moore = 4'b0011;
        endcase
    endfunction

    logic          access;
    logic          wr;
    logic [9:0]    widx;
    logic          addr_ok;
    logic [N-1:0]  target_reg;
    logic [N-1:0]  pend_reg;
    logic [N-1:0]  en_reg;
    logic [7:0]    settle_reg;
    logic [7:0]    settle_load;
    logic [N-1:0]  clr;
    logic [N-1:0]  done_pulse;
    logic [N-1:0]  on_vec;
    logic [N-1:0]  busy_vec;
    logic [N-1:0]  ack_s1_reg;
    logic [N-1:0]  ack_s2_reg;
    logic [7:0]    on8;
    logic [7:0]    busy8;
    logic          unused;

    assign access    = psel_i & penable_i;
    assign wr        = access & pwrite_i;
    assign widx      = paddr_i[11:2];
    assign addr_ok   = (widx < 10'd5);
    assign pready_o  = access;
    assign pslverr_o = access & ~addr_ok;
    assign irq_o     = |(pend_reg & en_reg);
    assign unused    = ^{paddr_i[AddrWidth-1:12], paddr_i[1:0], pwdata_i[31:8], pstrb_i[3:1]};

    assign settle_load = (settle_reg == 8'd0) ? 8'd0 : settle_reg - 8'd1;
    assign clr = (wr && widx == 10'd3 && pstrb_i[0]) ? pwdata_i[N-1:0] : '0;

    always_comb begin
        on8   = '0;
        busy8 = '0;
        on8[N-1:0]   = on_vec;
        busy8[N-1:0] = busy_vec;
        prdata_o = '0;
        if (access && addr_ok) begin
            case (widx)
                10'd0:   prdata_o = {{(32-N){1'b0}}, target_reg};
                10'd1:   prdata_o = {16'd0, busy8, on8};
                10'd2:   prdata_o = {24'd0, settle_reg};
                10'd3:   prdata_o = {{(32-N){1'b0}}, pend_reg};
                10'd4:   prdata_o = {{(32-N){1'b0}}, en_reg};
                default: prdata_o = '0;
            endcase
        end
    end

    // Completion set is OR'd in after the clear so a colliding W1C loses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            target_reg <= '0;
            settle_reg <= 8'd8;
            pend_reg   <= '0;
            en_reg     <= '0;
        end else begin
            if (wr && addr_ok && pstrb_i[0]) begin
                case (widx)
                    10'd0:   target_reg <= pwdata_i[N-1:0];
                    10'd2:   settle_reg <= pwdata_i[7:0];
                    10'd4:   en_reg     <= pwdata_i[N-1:0];
                    default: ;
                endcase
            end
            pend_reg <= (pend_reg & ~clr) | done_pulse;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_s1_reg <= '0;
            ack_s2_reg <= '0;
        end else begin
            ack_s1_reg <= pwr_ack_i;
            ack_s2_reg <= ack_s1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cluster
            state_t     st_reg;
            state_t     st_next;
            logic [7:0] cnt_reg;
            logic [7:0] cnt_next;
            logic [3:0] outs_reg;

            always_comb begin
                st_next  = st_reg;
                cnt_next = (cnt_reg != 8'd0) ? cnt_reg - 8'd1 : 8'd0;
                case (st_reg)
                    S_OFF:    if (target_reg[gi])  st_next = S_PWR_UP;
                    S_PWR_UP: if (ack_s2_reg[gi])  st_next = S_CLK_UP;
                    S_CLK_UP: if (cnt_reg == 8'd0) st_next = S_RST_UP;
                    S_RST_UP: if (cnt_reg == 8'd0) st_next = S_ON;
                    S_ON:     if (!target_reg[gi]) st_next = S_ISO_DN;
                    S_ISO_DN: if (cnt_reg == 8'd0) st_next = S_RST_DN;
                    S_RST_DN: if (cnt_reg == 8'd0) st_next = S_PWR_DN;
                    S_PWR_DN: if (!ack_s2_reg[gi]) st_next = S_OFF;
                    default:  st_next = S_OFF;
                endcase
                if (st_next != st_reg)
                    cnt_next = settle_load;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    st_reg   <= S_OFF;
                    cnt_reg  <= 8'd0;
                    outs_reg <= 4'b0011;
                end else begin
                    st_reg   <= st_next;
                    cnt_reg  <= cnt_next;
                    outs_reg <= moore(st_next);
                end
            end

            assign done_pulse[gi]    = (st_next != st_reg) && (st_next == S_ON || st_next == S_OFF);
            assign on_vec[gi]        = (st_reg == S_ON);
            assign busy_vec[gi]      = (st_reg != S_ON) && (st_reg != S_OFF);
            assign pwr_req_o[gi]     = outs_reg[3];
            assign clk_en_o[gi]      = outs_reg[2];
            assign cluster_rst_o[gi] = outs_reg[1];
            assign iso_o[gi]         = outs_reg[0];
        end
    endgenerate
endmodule
